cordic_range_reduce: RTL

- Wraps the CORDIC engine so callers can supply any angle in [-pi, +pi]. The engine itself converges only in [-pi/2, +pi/2].
- Pre-stage: folds the angle into engine range, then drives the engine inputs.
- Post-stage: consumes the engine results and negates cos/sin for folded transactions.
- Sits between the SPI command FSM and the CORDIC engine. Tracks in-flight fold flags in a tag FIFO, because the engine pipeline has no backpressure.

---
 rtl/cordic_pkg.sv | 25 ++
 rtl/cordic_tag_fifo.sv | 66 ++++++
 rtl/cordic_range_reduce.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared constants and the fold/clamp tag type for the CORDIC
//               range-reduction wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int TAG_DEPTH  = 16;

    // Angles are Q3.12 radians.
    localparam logic signed [15:0] PI_Q      = 16'sd12868;
    localparam logic signed [15:0] PI_HALF_Q = 16'sd6434;

    typedef struct packed {
        logic flip;
        logic clamp;
    } tag_t;

    localparam int TAG_WIDTH = $bits(tag_t);

endpackage : cordic_pkg
`default_nettype wire

// File: rtl/cordic_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cordic_tag_fifo
// Description : Synchronous circular-buffer FIFO holding per-transaction tags
//               while requests travel through the CORDIC engine.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    // A simultaneous pop frees the slot being written, so push is legal at full.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule : cordic_tag_fifo
`default_nettype wire

// File: rtl/cordic_range_reduce.sv
`default_nettype none
// ============================================================================
// Module      : cordic_range_reduce
// Description : Folds full-circle angles into the CORDIC engine's convergence
//               range and undoes the fold on the engine's cos/sin results.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_range_reduce
    import cordic_pkg::tag_t;
#(
    parameter int                             DATA_WIDTH = cordic_pkg::DATA_WIDTH,
    parameter logic signed [DATA_WIDTH-1:0]   PI_Q       = cordic_pkg::PI_Q,
    parameter logic signed [DATA_WIDTH-1:0]   PI_HALF_Q  = cordic_pkg::PI_HALF_Q,
    parameter int                             TAG_DEPTH  = cordic_pkg::TAG_DEPTH
) (
    input  logic                          i_clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic signed [DATA_WIDTH-1:0]  i_x,
    input  logic signed [DATA_WIDTH-1:0]  i_y,
    input  logic signed [DATA_WIDTH-1:0]  i_alpha,
    output logic                          o_eng_valid,
    output logic signed [DATA_WIDTH-1:0]  o_eng_x,
    output logic signed [DATA_WIDTH-1:0]  o_eng_y,
    output logic signed [DATA_WIDTH-1:0]  o_eng_alpha,
    input  logic                          i_eng_valid,
    input  logic signed [DATA_WIDTH-1:0]  i_eng_cos,
    input  logic signed [DATA_WIDTH-1:0]  i_eng_sin,
    input  logic signed [DATA_WIDTH-1:0]  i_eng_alpha,
    output logic                          o_valid,
    output logic signed [DATA_WIDTH-1:0]  o_cos,
    output logic signed [DATA_WIDTH-1:0]  o_sin,
    output logic signed [DATA_WIDTH-1:0]  o_alpha,
    output logic                          o_flip,
    output logic                          o_clamp,
    output logic                          o_err
);

    localparam int                           AW        = $clog2(TAG_DEPTH);
    localparam logic [AW:0]                  DEPTH_CNT = (AW+1)'(TAG_DEPTH);
    localparam logic signed [DATA_WIDTH-1:0] S_MIN     = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] S_MAX     = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic                          accept;
    logic                          eng_pop;
    logic                          tag_full;
    logic                          tag_empty;
    logic [AW:0]                   tag_count;
    tag_t                          push_tag;
    tag_t                          pop_tag;
    logic signed [DATA_WIDTH-1:0]  alpha_clamped;
    logic signed [DATA_WIDTH-1:0]  alpha_fold;
    logic                          clamp;
    logic                          flip;
    logic signed [DATA_WIDTH-1:0]  cos_neg;
    logic signed [DATA_WIDTH-1:0]  sin_neg;

    assign o_ready = (tag_count < DEPTH_CNT);
    assign accept  = i_valid & o_ready;
    assign eng_pop = i_eng_valid & ~tag_empty;

    always_comb begin
        clamp         = 1'b0;
        alpha_clamped = i_alpha;
        if (i_alpha > PI_Q) begin
            alpha_clamped = PI_Q;
            clamp         = 1'b1;
        end else if (i_alpha < -PI_Q) begin
            alpha_clamped = -PI_Q;
            clamp         = 1'b1;
        end

        // Rotating by pi negates both outputs; exactly +/-pi/2 stays unfolded.
        flip       = 1'b0;
        alpha_fold = alpha_clamped;
        if (alpha_clamped > PI_HALF_Q) begin
            alpha_fold = alpha_clamped - PI_Q;
            flip       = 1'b1;
        end else if (alpha_clamped < -PI_HALF_Q) begin
            alpha_fold = alpha_clamped + PI_Q;
            flip       = 1'b1;
        end
    end

    assign push_tag = '{flip: flip, clamp: clamp};

    // The most negative code has no positive twin; saturate instead of wrapping.
    assign cos_neg = (i_eng_cos == S_MIN) ? S_MAX : -i_eng_cos;
    assign sin_neg = (i_eng_sin == S_MIN) ? S_MAX : -i_eng_sin;

    cordic_tag_fifo #(
        .WIDTH (cordic_pkg::TAG_WIDTH),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .i_clk     (i_clk),
        .rst_n     (rst_n),
        .push      (accept & ~tag_full),
        .push_data (push_tag),
        .pop       (eng_pop),
        .pop_data  (pop_tag),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            o_eng_valid <= 1'b0;
            o_eng_x     <= '0;
            o_eng_y     <= '0;
            o_eng_alpha <= '0;
        end else begin
            o_eng_valid <= accept;
            if (accept) begin
                o_eng_x     <= i_x;
                o_eng_y     <= i_y;
                o_eng_alpha <= alpha_fold;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_cos   <= '0;
            o_sin   <= '0;
            o_alpha <= '0;
            o_flip  <= 1'b0;
            o_clamp <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_valid <= eng_pop;
            if (eng_pop) begin
                o_cos   <= pop_tag.flip ? cos_neg : i_eng_cos;
                o_sin   <= pop_tag.flip ? sin_neg : i_eng_sin;
                o_alpha <= i_eng_alpha;
                o_flip  <= pop_tag.flip;
                o_clamp <= pop_tag.clamp;
            end
            if (i_eng_valid && tag_empty) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule : cordic_range_reduce
`default_nettype wire
